// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the load/store responder: access-size encodings,
// FSM states and the latched request record.
package data_mem_responder_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } mem_req_t;

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Byte-lane steering for RV32I loads/stores: lane enables, replicated store
// data, sign/zero-extended load data and the misalign/illegal-funct3 flag.
module data_mem_responder_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic        write_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_word_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_word_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = addr_lo_i[1] ? rdata_word_i[31:16] : rdata_word_i[15:0];

  // Load and store share the B/H/W encodings; the unsigned ones exist only for loads.
  always_comb begin
    byte_en_o = 4'b0000;
    wdata_o   = 32'd0;
    rdata_o   = 32'd0;
    err_o     = 1'b0;
    unique case (funct3_i)
      LB: begin
        byte_en_o = 4'b0001 << addr_lo_i;
        wdata_o   = {4{wdata_i[7:0]}};
        rdata_o   = {{24{byte_sel[7]}}, byte_sel};
      end
      LH: begin
        byte_en_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o   = {2{wdata_i[15:0]}};
        rdata_o   = {{16{half_sel[15]}}, half_sel};
        err_o     = addr_lo_i[0];
      end
      LW: begin
        byte_en_o = 4'b1111;
        wdata_o   = wdata_i;
        rdata_o   = rdata_word_i;
        err_o     = |addr_lo_i;
      end
      LBU: begin
        rdata_o = {24'd0, byte_sel};
        err_o   = write_i;
      end
      LHU: begin
        rdata_o = {16'd0, half_sel};
        err_o   = write_i | addr_lo_i[0];
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Wait-state memory responder: accepts one load/store, waits WAIT_CYCLES,
// commits on the edge entering RESP and holds the response until taken.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_funct3_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  mem_req_t    req_q, req_d;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept, commit, err, range_err, align_err;
  logic [AW-1:0] widx;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_sh, ld_data, rdata_word;

  assign accept = req_valid_i && (state_q == IDLE);

  // With zero wait states the commit edge is the accept edge, so the commit
  // path always looks at req_d, which is the incoming request in that case.
  assign req_d = accept ? '{write: req_write_i, addr: req_addr_i,
                            wdata: req_wdata_i, funct3: req_funct3_i} : req_q;

  assign commit     = rst_ni && (state_q != RESP) && (state_d == RESP);
  assign widx       = req_d.addr[AW+1:2];
  assign range_err  = {2'b00, req_d.addr[31:2]} >= 32'(DEPTH_WORDS);
  assign err        = range_err | align_err;
  assign rdata_word = mem_q[widx];

  data_mem_responder_lane_align u_align (
    .write_i     (req_d.write),
    .funct3_i    (req_d.funct3),
    .addr_lo_i   (req_d.addr[1:0]),
    .wdata_i     (req_d.wdata),
    .rdata_word_i(rdata_word),
    .byte_en_o   (byte_en),
    .wdata_o     (wdata_sh),
    .rdata_o     (ld_data),
    .err_o       (align_err)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
      req_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      req_q      <= req_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      IDLE: if (req_valid_i) begin
        if (WAIT_CYCLES > 0) begin
          state_d    = WAIT;
          wait_cnt_d = WAIT_INIT;
        end else begin
          state_d = RESP;
        end
      end
      WAIT: if (wait_cnt_q == 4'd0) state_d = RESP;
            else                    wait_cnt_d = wait_cnt_q - 4'd1;
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == IDLE);
    rsp_valid_o = (state_q == RESP);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else if (commit) begin
      rsp_rdata_q <= (req_d.write || err) ? 32'd0 : ld_data;
      rsp_err_q   <= err;
    end else if (state_q == RESP && rsp_ready_i) begin
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end
  end

  // Array is deliberately outside the reset domain; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (commit && req_d.write && !err) begin
      for (int l = 0; l < 4; l++) begin
        if (byte_en[l]) mem_q[widx][8*l +: 8] <= wdata_sh[8*l +: 8];
      end
    end
  end

  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
